// File: rtl/ssd_pkg.sv
// Shared definitions for the two-digit multiplexed 7-segment display link.
// The glyph table is the single source of truth for both the display
// driver (nibble -> segments) and the capture side (segments -> nibble).
// Segment bus order is {g,f,e,d,c,b,a}, active-high, bit0 = a.
package ssd_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_GLYPH [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        SETTLE    = 2'd1,
        SAMPLE    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/ssd_seg2hex.sv
// Reverse glyph lookup: maps a 7-segment pattern back to its hex nibble.
// Ports:
//   seg_i    : segment pattern {g..a}
//   hit_o    : 1 when seg_i is one of the 16 hex glyphs
//   nibble_o : recovered nibble (0 when hit_o is 0)
module ssd_seg2hex
    import ssd_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b0;
        nibble_o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (seg_i == SEG_GLYPH[i]) begin
                hit_o    = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/ssd_mux_capture.sv
// Receive side of the two-digit multiplexed 7-segment display link.
// Synchronises sel/seg, waits for the segment bus to settle after each sel
// edge, decodes the digit and assembles {upper,lower} frames. A frame is
// published once it has been seen STABLE_FRAMES times in a row.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   sel_in      : 1 = upper-nibble digit, 0 = lower-nibble digit
//   seg_in      : segments {g..a}, active-high
//   data_out    : last published byte {upper,lower}
//   data_valid  : 1-cycle pulse when data_out updates
//   locked      : last frame decoded cleanly and link alive
//   seg_error   : 1-cycle pulse on a non-glyph sample
//   link_lost   : no sel edge for TIMEOUT_CYCLES
module ssd_mux_capture
    import ssd_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel_in,
    input  logic [6:0] seg_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       locked,
    output logic       seg_error,
    output logic       link_lost
);

    localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int STW = $clog2(STABLE_FRAMES + 1);
    localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [STW-1:0] STABLE_MAX  = STW'(STABLE_FRAMES);
    localparam logic [15:0]    TOUT_MAX    = 16'(TIMEOUT_CYCLES);

    // Synchronisers
    logic [SYNC_STAGES-1:0] sel_sync_q;
    logic [6:0]             seg_sync_q [SYNC_STAGES];
    logic                   sel_s;
    logic [6:0]             seg_s;

    assign sel_s = sel_sync_q[SYNC_STAGES-1];
    assign seg_s = seg_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_sync_q <= '0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                seg_sync_q[i] <= '0;
            end
        end else begin
            sel_sync_q <= {sel_sync_q[SYNC_STAGES-2:0], sel_in};
            seg_sync_q[0] <= seg_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                seg_sync_q[i] <= seg_sync_q[i-1];
            end
        end
    end

    // Decoder
    logic       hit;
    logic [3:0] nib;

    ssd_seg2hex u_seg2hex (
        .seg_i    (seg_s),
        .hit_o    (hit),
        .nibble_o (nib)
    );

    // State
    cap_state_e     state_q, state_d;
    logic           sel_prev_q;
    logic [SW-1:0]  settle_q, settle_d;
    logic           phase_q, phase_d;
    logic [3:0]     up_q, up_d;
    logic [3:0]     lo_q, lo_d;
    logic           up_ok_q, up_ok_d;
    logic           lo_ok_q, lo_ok_d;
    logic [7:0]     prev_frame_q, prev_frame_d;
    logic [STW-1:0] stable_q, stable_d;
    logic [7:0]     data_q, data_d;
    logic           pub_any_q, pub_any_d;
    logic           valid_q, valid_d;
    logic           locked_q, locked_d;
    logic           err_q, err_d;
    logic [15:0]    tout_q, tout_d;

    logic       sel_edge;
    logic       lost;
    logic [7:0] frame;

    assign sel_edge = sel_s ^ sel_prev_q;
    assign lost     = (tout_q == TOUT_MAX);

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        phase_d      = phase_q;
        up_d         = up_q;
        lo_d         = lo_q;
        up_ok_d      = up_ok_q;
        lo_ok_d      = lo_ok_q;
        prev_frame_d = prev_frame_q;
        stable_d     = stable_q;
        data_d       = data_q;
        pub_any_d    = pub_any_q;
        valid_d      = 1'b0;
        locked_d     = locked_q;
        err_d        = 1'b0;
        frame        = {up_q, nib};

        if (sel_edge) begin
            tout_d = '0;
        end else if (!lost) begin
            tout_d = tout_q + 16'd1;
        end else begin
            tout_d = tout_q;
        end

        unique case (state_q)
            WAIT_EDGE: begin
                if (sel_edge) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LOAD;
                    phase_d  = sel_s;
                end
            end
            SETTLE: begin
                // A fresh edge abandons the current phase and restarts settling.
                if (sel_edge) begin
                    settle_d = SETTLE_LOAD;
                    phase_d  = sel_s;
                end else if (settle_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            SAMPLE: begin
                if (!hit) begin
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    up_ok_d  = 1'b0;
                    lo_ok_d  = 1'b0;
                    stable_d = '0;
                end else if (phase_q) begin
                    up_d    = nib;
                    up_ok_d = 1'b1;
                end else begin
                    lo_d    = nib;
                    lo_ok_d = 1'b1;
                    if (up_ok_q) begin
                        up_ok_d      = 1'b0;
                        lo_ok_d      = 1'b0;
                        locked_d     = 1'b1;
                        prev_frame_d = frame;
                        if (frame != prev_frame_q) begin
                            stable_d = STW'(1);
                        end else if (stable_q != STABLE_MAX) begin
                            stable_d = stable_q + 1'b1;
                        end
                        if (stable_d == STABLE_MAX &&
                            (frame != data_q || !pub_any_q)) begin
                            data_d    = frame;
                            valid_d   = 1'b1;
                            pub_any_d = 1'b1;
                        end
                    end
                end
                if (sel_edge) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LOAD;
                    phase_d  = sel_s;
                end else begin
                    state_d = WAIT_EDGE;
                end
            end
            default: state_d = WAIT_EDGE;
        endcase

        // Lost link overrides everything except an edge that revives it.
        if (lost) begin
            up_ok_d  = 1'b0;
            lo_ok_d  = 1'b0;
            stable_d = '0;
            locked_d = 1'b0;
            valid_d  = 1'b0;
            err_d    = 1'b0;
            data_d   = data_q;
            if (!sel_edge) begin
                state_d = WAIT_EDGE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_EDGE;
            sel_prev_q   <= 1'b0;
            settle_q     <= '0;
            phase_q      <= 1'b0;
            up_q         <= '0;
            lo_q         <= '0;
            up_ok_q      <= 1'b0;
            lo_ok_q      <= 1'b0;
            prev_frame_q <= '0;
            stable_q     <= '0;
            data_q       <= '0;
            pub_any_q    <= 1'b0;
            valid_q      <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            tout_q       <= '0;
        end else begin
            state_q      <= state_d;
            sel_prev_q   <= sel_s;
            settle_q     <= settle_d;
            phase_q      <= phase_d;
            up_q         <= up_d;
            lo_q         <= lo_d;
            up_ok_q      <= up_ok_d;
            lo_ok_q      <= lo_ok_d;
            prev_frame_q <= prev_frame_d;
            stable_q     <= stable_d;
            data_q       <= data_d;
            pub_any_q    <= pub_any_d;
            valid_q      <= valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            tout_q       <= tout_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign locked     = locked_q;
    assign seg_error  = err_q;
    assign link_lost  = lost;

endmodule

// File: tb/tb_ssd_mux_capture.sv
// Bench for ssd_mux_capture: a behavioural display driver feeds the link,
// expected published bytes go into a queue, and a monitor pops and checks
// them whenever data_valid pulses.
module tb_ssd_mux_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel_in = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic       seg_error;
    logic       link_lost;

    int vectors = 0;
    int miscompares = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q [$];

    localparam logic [6:0] G [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    ssd_mux_capture #(
        .SYNC_STAGES    (2),
        .SETTLE_CYCLES  (4),
        .STABLE_FRAMES  (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_in     (sel_in),
        .seg_in     (seg_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .seg_error  (seg_error),
        .link_lost  (link_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && seg_error) err_cnt++;
        if (rst_n && data_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got data_out 0x%0h with no expected entry at %0t",
                         data_out, $time);
            end else begin
                chk("sb_data", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic phase(input logic s, input logic [6:0] g, input int n);
        sel_in = s;
        seg_in = g;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] v);
        phase(1'b1, G[v[7:4]], 8);
        phase(1'b0, G[v[3:0]], 8);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vc;
        // 1: reset held while the link toggles
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            phase(i[0] ? 1'b0 : 1'b1, G[i], 3);
        end
        sel_in = 1'b0;
        idle(2);
        chk("rst_data_out", {24'h0, data_out}, 32'h0);
        chk("rst_valid", {31'h0, data_valid}, 32'h0);
        chk("rst_locked", {31'h0, locked}, 32'h0);
        chk("rst_seg_error", {31'h0, seg_error}, 32'h0);
        chk("rst_link_lost", {31'h0, link_lost}, 32'h0);
        rst_n = 1'b1;
        idle(3);

        // 2: 0x3C published once after two frames
        exp_q.push_back(8'h3C);
        frame(8'h3C);
        idle(4);
        chk("no_valid_after_1_frame", valid_cnt, 0);
        frame(8'h3C);
        idle(4);
        chk("valid_after_2_frames", valid_cnt, 1);
        chk("data_3C", {24'h0, data_out}, 32'h3C);
        chk("locked_3C", {31'h0, locked}, 32'h1);
        frame(8'h3C);
        frame(8'h3C);
        idle(4);
        chk("no_repulse", valid_cnt, 1);

        // 4: one non-glyph phase
        phase(1'b1, G[3], 8);
        phase(1'b0, 7'h7E, 8);
        idle(2);
        chk("seg_error_pulses", err_cnt, 1);
        chk("locked_dropped", {31'h0, locked}, 32'h0);
        chk("data_held_err", {24'h0, data_out}, 32'h3C);
        frame(8'h3C);
        frame(8'h3C);
        idle(4);
        chk("relocked", {31'h0, locked}, 32'h1);
        chk("no_valid_relock", valid_cnt, 1);

        // 6: 2-cycle sel glitch with a bad pattern inside SETTLE
        phase(1'b1, G[3], 4);
        phase(1'b0, 7'h7E, 2);
        phase(1'b1, G[3], 10);
        phase(1'b0, G[12], 8);
        idle(4);
        chk("glitch_no_error", err_cnt, 1);
        chk("glitch_data", {24'h0, data_out}, 32'h3C);
        chk("glitch_no_valid", valid_cnt, 1);

        // 3: value change mid-frame, only 0xA5 may appear
        exp_q.push_back(8'hA5);
        phase(1'b1, G[3], 8);
        phase(1'b0, G[5], 8);
        frame(8'hA5);
        frame(8'hA5);
        idle(4);
        chk("valid_A5", valid_cnt, 2);
        chk("data_A5", {24'h0, data_out}, 32'hA5);

        // 5: link loss after 100 cycles without an edge
        phase(1'b1, G[10], 8);
        phase(1'b0, G[5], 8);
        idle(92);
        chk("not_lost_yet", {31'h0, link_lost}, 32'h0);
        idle(6);
        chk("link_lost", {31'h0, link_lost}, 32'h1);
        chk("lost_unlocked", {31'h0, locked}, 32'h0);
        chk("lost_data_held", {24'h0, data_out}, 32'hA5);
        phase(1'b1, G[10], 8);
        chk("link_restored", {31'h0, link_lost}, 32'h0);
        phase(1'b0, G[5], 8);
        frame(8'hA5);
        idle(4);
        chk("relock_after_loss", {31'h0, locked}, 32'h1);
        vc = valid_cnt;
        chk("no_valid_after_loss", vc, 2);

        idle(4);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("total_seg_errors", err_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
